bus_reg_file: RTL

//  Parametrised bank of NREGS bidirectional bus registers on the shared CPU data bus; replaces hand-instanced A/B/general/OUT registers.

---
 rtl/bat_bus_pkg.sv | 20 ++
 rtl/bus_reg_file_if.sv | 34 +++
 rtl/bus_reg_cell.sv | 62 ++++++
 rtl/bus_reg_file.sv | 73 +++++++
 4 files changed

// File: rtl/bat_bus_pkg.sv
// Shared definitions for the bus register file.
//   RW_LOAD / RW_DRIVE : meaning of a REGS_RW bit when its REGS_EN bit is set
//   WIDTH_DEF / NREGS_DEF : default data width and register count
//   popcount16 : counts the set bits of a word of up to 16 bits (driver count)
package bat_bus_pkg;

    localparam int   WIDTH_DEF = 16;
    localparam int   NREGS_DEF = 8;

    localparam logic RW_LOAD   = 1'b1;
    localparam logic RW_DRIVE  = 1'b0;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/bus_reg_file_if.sv
// Control/status bundle of the bus register file.
//   master : the controller (drives selects, inc/dec, clears; observes taps/flags)
//   slave  : the register file
// BUS itself is a resolved tri-state net and stays a plain inout port.
// BUS_OE shows when the register file is the one driving BUS.
interface bus_reg_file_if #(
    parameter int WIDTH = bat_bus_pkg::WIDTH_DEF,
    parameter int NREGS = bat_bus_pkg::NREGS_DEF
);
    logic [NREGS-1:0] REGS_EN;
    logic [NREGS-1:0] REGS_RW;
    logic [NREGS-1:0] REGS_INC;
    logic [NREGS-1:0] REGS_DEC;
    logic             CARRY_CLR;
    logic             CONTENTION_CLR;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [WIDTH-1:0] OUT;
    logic [NREGS-1:0] ZERO;
    logic [NREGS-1:0] CARRY;
    logic             CONTENTION;
    logic             BUS_OE;

    modport master (
        output REGS_EN, REGS_RW, REGS_INC, REGS_DEC, CARRY_CLR, CONTENTION_CLR,
        input  ALU_A, ALU_B, OUT, ZERO, CARRY, CONTENTION, BUS_OE
    );

    modport slave (
        input  REGS_EN, REGS_RW, REGS_INC, REGS_DEC, CARRY_CLR, CONTENTION_CLR,
        output ALU_A, ALU_B, OUT, ZERO, CARRY, CONTENTION, BUS_OE
    );

endinterface

// File: rtl/bus_reg_cell.sv
// One bus register: load from BUS, in-place inc/dec with sticky wrap flag.
//   CLK, RST          : clock, async active-low reset
//   i_en, i_rw        : select and direction (RW_LOAD / RW_DRIVE)
//   i_inc, i_dec      : count requests (both together = hold)
//   i_carry_clr       : clear the wrap flag (a wrap in the same cycle wins)
//   i_bus             : resolved BUS value, sampled on load
//   o_q               : register contents
//   o_drive_req       : this cell wants to drive BUS this cycle
//   o_zero, o_carry   : contents == 0, sticky wrap flag
module bus_reg_cell import bat_bus_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_en,
    input  logic             i_rw,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_carry_clr,
    input  logic [WIDTH-1:0] i_bus,
    output logic [WIDTH-1:0] o_q,
    output logic             o_drive_req,
    output logic             o_zero,
    output logic             o_carry
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic             w_load;
    logic             w_up;
    logic             w_dn;
    logic             w_wrap;

    assign w_load      = i_en && (i_rw == RW_LOAD);
    assign o_drive_req = i_en && (i_rw == RW_DRIVE);

    // Load masks counting; inc and dec together cancel out.
    assign w_up   = !w_load && i_inc && !i_dec;
    assign w_dn   = !w_load && i_dec && !i_inc;
    assign w_wrap = (w_up && (&r_q)) || (w_dn && (r_q == '0));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q     <= '0;
            r_carry <= 1'b0;
        end else begin
            if (w_load)    r_q <= i_bus;
            else if (w_up) r_q <= r_q + ONE;
            else if (w_dn) r_q <= r_q - ONE;

            if (w_load)           r_carry <= 1'b0;
            else if (w_wrap)      r_carry <= 1'b1;
            else if (i_carry_clr) r_carry <= 1'b0;
        end
    end

    assign o_q     = r_q;
    assign o_zero  = (r_q == '0);
    assign o_carry = r_carry;

endmodule

// File: rtl/bus_reg_file.sv
// Bank of NREGS bidirectional registers on a shared tri-state data bus.
//   CLK, RST : clock, async active-low reset
//   BUS      : shared tri-state data bus (loaded from / driven onto)
//   bif      : control inputs, ALU_A/ALU_B/OUT taps, ZERO/CARRY/CONTENTION flags
// NREGS must lie in 2..16 (driver count is a 16-bit popcount).
module bus_reg_file import bat_bus_pkg::*; #(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int TAP_A   = 0,
    parameter int TAP_B   = 1,
    parameter int OUT_IDX = NREGS - 1
) (
    input  logic             CLK,
    input  logic             RST,
    inout  wire  [WIDTH-1:0] BUS,
    bus_reg_file_if.slave    bif
);
    logic [NREGS-1:0][WIDTH-1:0] w_q;
    logic [NREGS-1:0]            w_drv;
    logic [NREGS-1:0]            w_zero;
    logic [NREGS-1:0]            w_carry;
    logic [4:0]                  w_ndrv;
    logic                        w_oe;
    logic                        w_multi;
    logic [WIDTH-1:0]            w_bus_out;
    logic                        r_cont;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_cell
        bus_reg_cell #(.WIDTH(WIDTH)) u_cell (
            .CLK         (CLK),
            .RST         (RST),
            .i_en        (bif.REGS_EN[gi]),
            .i_rw        (bif.REGS_RW[gi]),
            .i_inc       (bif.REGS_INC[gi]),
            .i_dec       (bif.REGS_DEC[gi]),
            .i_carry_clr (bif.CARRY_CLR),
            .i_bus       (BUS),
            .o_q         (w_q[gi]),
            .o_drive_req (w_drv[gi]),
            .o_zero      (w_zero[gi]),
            .o_carry     (w_carry[gi])
        );
    end

    assign w_ndrv  = popcount16(16'(w_drv));
    assign w_multi = (w_ndrv > 5'd1);
    // Only a lone driver gets the bus; reset releases it regardless of controls.
    assign w_oe    = RST && (w_ndrv == 5'd1);

    // OR-mux is exact because it is only used when w_drv is one-hot.
    always_comb begin
        w_bus_out = '0;
        for (int i = 0; i < NREGS; i++)
            if (w_drv[i]) w_bus_out = w_bus_out | w_q[i];
    end

    assign BUS = w_oe ? w_bus_out : 'z;

    // Fresh contention outranks a same-cycle clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_cont <= 1'b0;
        else      r_cont <= w_multi || (r_cont && !bif.CONTENTION_CLR);
    end

    assign bif.ALU_A      = w_q[TAP_A];
    assign bif.ALU_B      = w_q[TAP_B];
    assign bif.OUT        = w_q[OUT_IDX];
    assign bif.ZERO       = w_zero;
    assign bif.CARRY      = w_carry;
    assign bif.CONTENTION = r_cont;
    assign bif.BUS_OE     = w_oe;

endmodule
